// File: rtl/ysyx_22050039_lsu_pkg.sv
// ysyx_22050039_lsu_pkg: size encodings, LSU state enum and lane/extension helpers.
package ysyx_22050039_lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_e;
  // Low NB bits are the first-beat lanes, the next NB bits spill into the second beat.
  function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    byte_mask = ((16'd1 << (4'd1 << size)) - 16'd1) << off;
  endfunction
  function automatic logic [63:0] sext(input logic [63:0] data, input logic [1:0] size, input logic sgn);
    logic [63:0] m;
    logic msb;
    m = (size == SZ_D) ? '1 : (64'd1 << (7'd8 << size)) - 64'd1;
    msb = data[6'((7'd8 << size) - 7'd1)];
    sext = (sgn && msb) ? (data | ~m) : (data & m);
  endfunction
endpackage

// File: rtl/ysyx_22050039_lsu_align.sv
// ysyx_22050039_lsu_align: write lane positioning across two beats and read merge/extension.
module ysyx_22050039_lsu_align
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]       i_size,
  input  logic             i_signed,
  input  logic [OFF_W-1:0] i_off,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [XLEN-1:0]  i_rdata0,
  input  logic [XLEN-1:0]  i_rdata1,
  output logic [XLEN-1:0]  o_wdata0,
  output logic [XLEN-1:0]  o_wdata1,
  output logic [NB-1:0]    o_mask0,
  output logic [NB-1:0]    o_mask1,
  output logic [XLEN-1:0]  o_rdata
);
  logic [2*XLEN-1:0] w_wide;
  logic [XLEN-1:0]   w_raw;
  logic [15:0]       w_mask;
  logic [63:0]       w_ext;
  assign w_wide = {{XLEN{1'b0}}, i_wdata} << {i_off, 3'b000};
  assign {o_wdata1, o_wdata0} = w_wide;
  assign w_mask = byte_mask(i_size, 3'(i_off));
  assign o_mask0 = w_mask[NB-1:0];
  assign o_mask1 = w_mask[2*NB-1:NB];
  assign w_raw = XLEN'({i_rdata1, i_rdata0} >> {i_off, 3'b000});
  assign w_ext = sext(64'(w_raw), i_size, i_signed);
  assign o_rdata = w_ext[XLEN-1:0];
endmodule

// File: rtl/ysyx_22050039_lsu.sv
// ysyx_22050039_lsu: multi-cycle load/store unit between execute, an aligned bus and writeback.
// Define YSYX_22050039_LSU_MISALIGN_EN to allow misaligned accesses (split into two beats when crossing).
module ysyx_22050039_lsu
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ADDR_W = 64,
  localparam int NB = XLEN / 8,
  localparam int OFF_W = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [NB-1:0]     mem_wmask,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);
  state_e            r_state;
  logic              r_we, r_signed, r_cross, r_err;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_rdata0, r_rdata;
  logic [3:0]        w_n;
  logic              w_cross, w_bad, w_ill, w_beat, w_b1, w_wr;
  logic [XLEN-1:0]   w_wd0, w_wd1, w_ld;
  logic [NB-1:0]     w_m0, w_m1;
  assign w_n = 4'd1 << req_size;
  assign w_cross = (5'(req_addr[OFF_W-1:0]) + 5'(w_n)) > 5'(NB);
  assign w_ill = (req_size == SZ_D) && (XLEN == 32);
`ifdef YSYX_22050039_LSU_MISALIGN_EN
  assign w_bad = w_ill;
`else
  assign w_bad = w_ill | (|(req_addr[2:0] & 3'(w_n - 4'd1)));
`endif
  assign w_beat = (r_state == S_BEAT0) || (r_state == S_BEAT1);
  assign w_b1 = r_state == S_BEAT1;
  assign w_wr = w_beat & r_we;
  assign req_ready = rst && (r_state == S_IDLE);
  assign mem_valid = w_beat;
  assign mem_we = w_wr;
  assign mem_addr = w_beat ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + (w_b1 ? ADDR_W'(NB) : '0) : '0;
  assign mem_wmask = w_wr ? (w_b1 ? w_m1 : w_m0) : '0;
  assign mem_wdata = w_wr ? (w_b1 ? w_wd1 : w_wd0) : '0;
  assign resp_valid = r_state == S_RESP;
  assign resp_rdata = r_rdata;
  assign resp_err = r_err;
  ysyx_22050039_lsu_align #(.XLEN(XLEN)) u_align (
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_off    (r_addr[OFF_W-1:0]),
    .i_wdata  (r_wdata),
    .i_rdata0 ((r_state == S_BEAT0) ? mem_rdata : r_rdata0),
    .i_rdata1 (r_cross ? mem_rdata : '0),
    .o_wdata0 (w_wd0),
    .o_wdata1 (w_wd1),
    .o_mask0  (w_m0),
    .o_mask1  (w_m1),
    .o_rdata  (w_ld)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_cross  <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata  <= '0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_we     <= req_we;
      r_signed <= req_signed;
      r_size   <= req_size;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_cross  <= w_cross;
      r_err    <= w_bad;
      r_rdata  <= '0;
      r_state  <= w_bad ? S_RESP : S_BEAT0;
    end else if (r_state == S_BEAT0 && mem_ready) begin
      r_rdata0 <= mem_rdata;
      r_rdata  <= (r_we || r_cross) ? '0 : w_ld;
      r_state  <= r_cross ? S_BEAT1 : S_RESP;
    end else if (r_state == S_BEAT1 && mem_ready) begin
      r_rdata  <= r_we ? '0 : w_ld;
      r_state  <= S_RESP;
    end else if (r_state == S_RESP && resp_ready) begin
      r_state  <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// tb_ysyx_22050039_lsu: randomized and directed checks of the LSU against a byte-array memory model.
module tb_ysyx_22050039_lsu;
  localparam logic [63:0] BASE = 64'h8000_0000;
`ifdef YSYX_22050039_LSU_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  logic mem_valid, mem_ready = 0, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [7:0] mem_wmask;
  logic resp_valid, resp_ready = 0, resp_err;
  logic [63:0] resp_rdata;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] bus_mem [128];
  logic [7:0] ref_mem [128];
  logic [63:0] got_rdata, last_mask0, last_mask1, last_wdata0, last_wdata1;
  logic got_err;

  always #5 clk = ~clk;

  ysyx_22050039_lsu dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bus_word(input logic [63:0] a);
    logic [63:0] w;
    int idx;
    w = '0;
    idx = int'(a - BASE);
    if (idx >= 0 && idx <= 120)
      for (int i = 0; i < 8; i++) w[8*i+:8] = bus_mem[idx+i];
    return w;
  endfunction

  task automatic set_word(input int o, input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      bus_mem[o+i] = v[8*i+:8];
      ref_mem[o+i] = v[8*i+:8];
    end
  endtask

  task automatic run_op(input logic we, input logic [1:0] sz, input logic sg, input int off,
                        input logic [63:0] wd, input int mst, input int rst_stall);
    int n, lo, nb, cyc, beats, st, idx, diffs;
    logic [63:0] a, exp_rd, m, d, b_addr, s_addr, s_mask, s_wdata, lanes;
    logic exp_err, s_we, snap;
    a = BASE + 64'(off);
    n = 1 << sz;
    lo = off % 8;
    exp_err = !MIS_EN && (off % n) != 0;
    nb = exp_err ? 0 : ((lo + n > 8) ? 2 : 1);
    exp_rd = '0;
    if (!we && !exp_err) begin
      for (int i = 0; i < n; i++) exp_rd[8*i+:8] = ref_mem[off+i];
      if (sg && n < 8 && exp_rd[8*n-1]) exp_rd = exp_rd | (~64'd0 << (8*n));
    end
    if (we && !exp_err)
      for (int i = 0; i < n; i++) ref_mem[off+i] = wd[8*i+:8];
    last_mask0 = '0; last_mask1 = '0; last_wdata0 = '0; last_wdata1 = '0;
    @(negedge clk);
    chk("req_ready", req_ready, 1);
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    cyc = 0; beats = 0; st = mst; snap = 0;
    s_addr = '0; s_mask = '0; s_wdata = '0; s_we = 0;
    forever begin
      @(negedge clk);
      cyc++;
      mem_ready = 0;
      mem_rdata = {$urandom, $urandom};
      if (resp_valid) break;
      if (cyc > 60) begin
        chk("timeout", 64'(cyc), 0);
        break;
      end
      if (mem_valid) begin
        if (!snap) begin
          snap = 1; s_addr = mem_addr; s_we = mem_we; s_mask = 64'(mem_wmask); s_wdata = mem_wdata;
          b_addr = (a & ~64'd7) + 64'(8 * beats);
          m = '0; d = '0; lanes = '0;
          if (we)
            for (int i = 0; i < n; i++)
              if (((a + 64'(i)) & ~64'd7) == b_addr) begin
                m[(a + 64'(i)) % 8] = 1'b1;
                d[8*((a + 64'(i)) % 8)+:8] = wd[8*i+:8];
                lanes[8*((a + 64'(i)) % 8)+:8] = 8'hFF;
              end
          chk("beat_addr", mem_addr, b_addr);
          chk("beat_we", 64'(mem_we), 64'(we));
          chk("beat_mask", 64'(mem_wmask), m);
          chk("beat_wdata", mem_wdata & lanes, d);
          if (beats == 0) begin last_mask0 = 64'(mem_wmask); last_wdata0 = mem_wdata; end
          else begin last_mask1 = 64'(mem_wmask); last_wdata1 = mem_wdata; end
        end else begin
          chk("beat_stable", 64'((mem_addr !== s_addr) || (mem_we !== s_we) ||
              (64'(mem_wmask) !== s_mask) || (mem_wdata !== s_wdata)), 0);
        end
        if (st > 0) st--;
        else begin
          mem_ready = 1;
          mem_rdata = bus_word(mem_addr);
          idx = int'(mem_addr - BASE);
          if (mem_we && idx >= 0 && idx <= 120)
            for (int i = 0; i < 8; i++) if (mem_wmask[i]) bus_mem[idx+i] = mem_wdata[8*i+:8];
          beats++; snap = 0; st = mst;
        end
      end
    end
    chk("beats", 64'(beats), 64'(nb));
    chk("latency", 64'(cyc), 64'(1 + nb * (mst + 1)));
    for (int k = 0; k < rst_stall; k++) begin
      chk("resp_hold_data", resp_rdata, exp_rd);
      chk("resp_hold_flags", {62'd0, resp_valid, resp_err}, {62'd0, 1'b1, exp_err});
      @(negedge clk);
    end
    resp_ready = 1;
    got_rdata = resp_rdata; got_err = resp_err;
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", 64'(resp_err), 64'(exp_err));
    @(posedge clk); #1;
    resp_ready = 0;
    chk("resp_done", 64'(resp_valid), 0);
    diffs = 0;
    for (int i = 0; i < 128; i++) if (bus_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 64'(diffs), 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    mem_ready = 1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_mem_valid", 64'(mem_valid), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_err", 64'(resp_err), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wmask", 64'(mem_wmask), 0);
    rst = 1;
    @(negedge clk);
    chk("idle_ignores_ready", 64'(mem_valid), 0);
    mem_ready = 0;

    set_word(8, 64'h1122334455667788);
    run_op(0, 2'd3, 0, 8, 64'd0, 0, 0);
    chk("ld_data", got_rdata, 64'h1122334455667788);
    set_word(0, 64'h0000_0000_8A00_0000);
    run_op(0, 2'd0, 1, 3, 64'd0, 0, 0);
    chk("lb_signed", got_rdata, 64'hFFFF_FFFF_FFFF_FF8A);
    run_op(0, 2'd0, 0, 3, 64'd0, 0, 0);
    chk("lb_unsigned", got_rdata, 64'h8A);
    run_op(1, 2'd1, 0, 6, 64'hABCD, 0, 0);
    chk("sh_mask", last_mask0, 64'hC0);
    chk("sh_wdata", last_wdata0, 64'hABCD_0000_0000_0000);
    run_op(1, 2'd2, 0, 6, 64'h1122_3344, 0, 0);
    chk("sw_err", 64'(got_err), 64'(!MIS_EN));
    chk("sw_mask0", last_mask0, MIS_EN ? 64'hC0 : 64'h0);
    chk("sw_mask1", last_mask1, MIS_EN ? 64'h03 : 64'h0);
    chk("sw_wdata0", last_wdata0 >> 48, MIS_EN ? 64'h3344 : 64'h0);
    chk("sw_wdata1", last_wdata1 & 64'hFFFF, MIS_EN ? 64'h1122 : 64'h0);
    set_word(8, 64'hBBAA_0000_0000_0000);
    set_word(16, 64'h0000_0000_0000_DDCC);
    run_op(0, 2'd2, 1, 14, 64'd0, 0, 0);
    chk("lw_split", got_rdata, MIS_EN ? 64'hFFFF_FFFF_DDCC_BBAA : 64'h0);
    run_op(1, 2'd3, 0, 24, {$urandom, $urandom}, 5, 3);
    run_op(0, 2'd3, 0, 24, 64'd0, 5, 3);

    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 2'd2; req_signed = 0;
    req_addr = BASE + (MIS_EN ? 64'd14 : 64'd16);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    repeat (MIS_EN ? 1 : 0) begin
      mem_ready = 1;
      @(negedge clk);
      mem_ready = 0;
    end
    chk("abort_pre_valid", 64'(mem_valid), 1);
    rst = 0;
    #1;
    chk("abort_mem_valid", 64'(mem_valid), 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_req_ready", 64'(req_ready), 0);
    chk("abort_resp_valid", 64'(resp_valid), 0);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("abort_no_resp", 64'(resp_valid), 0);
    set_word(32, 64'hCAFE_F00D_1234_5678);
    run_op(0, 2'd3, 0, 32, 64'd0, 0, 0);
    chk("post_rst_ld", got_rdata, 64'hCAFE_F00D_1234_5678);

    for (int t = 0; t < 40; t++)
      run_op(1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 111)),
             {$urandom, $urandom}, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22050039_lsu.md
Name: ysyx_22050039_lsu

Overview:
Parametrised multi-cycle load/store unit that replaces direct DPI memory calls in execute.
- Accepts one memory request from execute over a valid/ready handshake.
- Drives an aligned XLEN-wide memory bus port, splitting boundary-crossing misaligned accesses into two beats when enabled.
- Returns zero/sign-extended load data, or a store acknowledgement, to writeback over a second valid/ready handshake.

Parameters:
XLEN, 64, data width in bits; 32 or 64. NB = XLEN/8, OFF_W = log2(NB).
ADDR_W, 64, address width in bits.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (rst=0 resets)
req_valid  in  1  request present
req_ready  out  1  LSU can accept request
req_we  in  1  1=store, 0=load
req_size  in  2  log2 bytes: 0=B, 1=H, 2=W, 3=D
req_signed  in  1  sign-extend load result
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, low bytes significant
mem_valid  out  1  bus beat present
mem_ready  in  1  bus beat completes this cycle; mem_rdata valid
mem_we  out  1  beat is write
mem_addr  out  ADDR_W  NB-aligned beat address
mem_wdata  out  XLEN  lane-positioned write data
mem_wmask  out  NB  byte write enables
mem_rdata  in  XLEN  aligned read word
resp_valid  out  1  result present
resp_ready  in  1  writeback accepts result
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  access fault

Behaviour:
- States: IDLE, BEAT0, BEAT1, RESP. Reset (rst=0, async) forces IDLE and clears all captured registers.
  - Outputs while in reset: req_ready=0, mem_valid=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_* = 0.
- req_ready = 1 only in IDLE with rst=1. On accept (req_valid & req_ready), capture all req_* fields.
- Derived values: off = addr[OFF_W-1:0]; n = 1<<size; cross = (off+n > NB).
- Illegal access: size=3 with XLEN=32 → IDLE→RESP, resp_err=1, no bus beat.
- IDLE on accept → BEAT0. An access that is misaligned without the optional feature goes IDLE→RESP with resp_err=1 and no bus beat (see Optional Feature).
- BEAT0: mem_valid=1.
  - mem_addr = addr with low OFF_W bits cleared.
  - mem_wmask = ((1<<n)-1)<<off, truncated to NB bits; mem_wdata = wdata<<(8*off).
  - On mem_ready → BEAT1 if cross, else RESP.
- BEAT1: mem_addr = BEAT0 address + NB, wrapping modulo 2^ADDR_W.
  - mem_wmask = ((1<<n)-1)>>(NB-off); mem_wdata = wdata>>(8*(NB-off)).
  - On mem_ready → RESP.
- Bus rules:
  - mem_valid, mem_we, mem_addr, mem_wdata and mem_wmask stay stable until mem_ready.
  - For loads, mem_wmask = 0.
  - mem_rdata is sampled only when mem_valid & mem_ready.
- Load assembly:
  - raw = (beat0_rdata>>(8*off)) | (cross ? beat1_rdata<<(8*(NB-off)) : 0).
  - Keep the low n bytes. Sign-extend from bit 8n-1 if req_signed, else zero-extend. size=3 (XLEN=64) is passed through unchanged.
- RESP: resp_valid=1; resp_rdata and resp_err are registered and stable until resp_ready. On resp_ready → IDLE.
  - New request acceptance earliest the cycle after the response handshake (no overlap).
- Latency with zero-wait bus: accept at cycle t; BEAT0 at t+1; resp_valid at t+2 (single beat) or t+3 (split).
- Reset mid-operation: beat abandoned immediately, no response produced; a partially written split store is not rolled back.
- mem_ready held high outside BEAT0/BEAT1 is ignored.

Optional Feature:
Macro: YSYX_22050039_LSU_MISALIGN_EN.
- Defined:
  - Misaligned accesses that stay within one NB word take one beat.
  - Accesses that cross an NB boundary are split into BEAT0 + BEAT1.
- Undefined:
  - Any access with addr not a multiple of n → IDLE→RESP, resp_err=1, resp_rdata=0, no bus beat.
  - BEAT1 is unreachable and may be omitted.

Decomposition:
- Package ysyx_22050039_lsu_pkg holds:
  - size encodings (SZ_B/H/W/D);
  - state enum;
  - helper functions byte_mask(size, off) and sext(data, size, signed).
- Sub-module ysyx_22050039_lsu_align: combinational read merge/extension and write lane positioning, instantiated once by the FSM module.

Test Plan (XLEN=64):
- Ld at 0x8000_0008, mem_rdata=0x1122334455667788, zero-wait bus → one beat:
  - mem_addr=0x8000_0008, wmask=0x00;
  - resp_rdata=0x1122334455667788 at accept+2.
- Lb at 0x8000_0003, mem_rdata=0x0000_0000_8A00_0000:
  - signed → resp_rdata=0xFFFF_FFFF_FFFF_FF8A;
  - unsigned → 0x8A.
- Sh at 0x8000_0006, wdata=0xABCD → mem_addr=0x8000_0000, wmask=0xC0, wdata=0xABCD_0000_0000_0000.
- Sw at 0x8000_0006, wdata=0x11223344:
  - EN: beat0 at 0x8000_0000, wmask=0xC0, wdata[63:48]=0x3344; beat1 at 0x8000_0008, wmask=0x03, wdata[15:0]=0x1122.
  - Not EN: resp_err=1, mem_valid never asserted.
- EN, signed Lw at 0x8000_000E, beat0 rdata=0xBBAA_0000_0000_0000, beat1 rdata=0x0000_0000_0000_DDCC → resp_rdata=0xFFFF_FFFF_DDCC_BBAA.
- Backpressure and reset:
  - mem_ready low 5 cycles → mem_* stable throughout.
  - resp_ready low 3 cycles → resp_* stable throughout.
  - rst=0 during BEAT1 → mem_valid=0 in the same cycle; after release, an Ld completes normally.
